// File: rtl/tinyqv_pkg.sv
// Shared TinyQV definitions: instruction length encoding used by the aligner, decoder and core.
package tinyqv_pkg;

  localparam logic [1:0] INSTR_LEN_16 = 2'b01;
  localparam logic [1:0] INSTR_LEN_32 = 2'b10;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/tinyqv_hw_fifo.sv
// Halfword shift FIFO: push at the tail, pop one or two from the head, clear.
module tinyqv_hw_fifo #(
  parameter int BUF_HW = 4,
  parameter int CW     = $clog2(BUF_HW + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic          pop,
  input  logic          pop_two,
  input  logic          clear,
  output logic [15:0]   hw0,
  output logic [15:0]   hw1,
  output logic [CW-1:0] count
);

  logic [15:0]   slot_q [BUF_HW];
  logic [15:0]   slot_d [BUF_HW];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] pop_n;
  logic [CW-1:0] wr_idx;

  always_comb begin
    pop_n  = pop ? (pop_two ? CW'(2) : CW'(1)) : '0;
    // The pushed halfword lands after whatever survives this cycle's pop.
    wr_idx = count_q - pop_n;
    for (int i = 0; i < BUF_HW; i++) begin
      slot_d[i] = '0;
      if (!pop) begin
        slot_d[i] = slot_q[i];
      end else if (!pop_two) begin
        if (i + 1 < BUF_HW) slot_d[i] = slot_q[(i + 1) % BUF_HW];
      end else begin
        if (i + 2 < BUF_HW) slot_d[i] = slot_q[(i + 2) % BUF_HW];
      end
      if (push && wr_idx == CW'(i)) slot_d[i] = push_data;
    end
    count_d = count_q - pop_n + (push ? CW'(1) : CW'(0));
    if (clear) begin
      count_d = '0;
      for (int i = 0; i < BUF_HW; i++) slot_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      for (int i = 0; i < BUF_HW; i++) slot_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < BUF_HW; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign hw0   = slot_q[0];
  assign hw1   = slot_q[1];
  assign count = count_q;

endmodule

// File: rtl/tinyqv_instr_aligner.sv
// Re-forms the fetched halfword stream into whole 16/32-bit instructions with their PC.
module tinyqv_instr_aligner
  import tinyqv_pkg::*;
#(
  parameter int PC_BITS = 24,
  parameter int BUF_HW  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [15:0]        fetch_data,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic               flush,
  input  logic [PC_BITS-1:0] flush_pc,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [1:0]         instr_len,
  output logic [PC_BITS-1:0] instr_pc,
  input  logic               instr_ack
);

  localparam int CW = $clog2(BUF_HW + 1);

  logic [15:0]        hw0;
  logic [15:0]        hw1;
  logic [CW-1:0]      count;
  logic               compressed;
  logic               do_push;
  logic               do_pop;
  logic [PC_BITS-1:0] pc_q;

  // Valid and ready depend only on registered state, so no input reaches them combinationally.
  assign compressed  = is_compressed(hw0);
  assign instr_len   = compressed ? INSTR_LEN_16 : INSTR_LEN_32;
  assign instr_valid = compressed ? (count != '0) : (count >= CW'(2));
  assign fetch_ready = count != CW'(BUF_HW);
  assign instr       = compressed ? {16'h0000, hw0} : {hw1, hw0};
  assign instr_pc    = pc_q;

  assign do_push = fetch_valid && fetch_ready && !flush;
  assign do_pop  = instr_ack && instr_valid && !flush;

  tinyqv_hw_fifo #(
    .BUF_HW (BUF_HW),
    .CW     (CW)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (do_push),
    .push_data (fetch_data),
    .pop       (do_pop),
    .pop_two   (!compressed),
    .clear     (flush),
    .hw0       (hw0),
    .hw1       (hw1),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= '0;
    end else if (flush) begin
      pc_q <= flush_pc & ~PC_BITS'(1);
    end else if (do_pop) begin
      pc_q <= pc_q + (compressed ? PC_BITS'(2) : PC_BITS'(4));
    end
  end

endmodule

// File: tb/tb_tinyqv_instr_aligner.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic against a queue model.
module tb_tinyqv_instr_aligner;

  localparam int PC_BITS = 24;
  localparam int BUF_HW  = 4;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [15:0]        fetch_data = '0;
  logic               fetch_valid = 1'b0;
  logic               fetch_ready;
  logic               flush = 1'b0;
  logic [PC_BITS-1:0] flush_pc = '0;
  logic [31:0]        instr;
  logic               instr_valid;
  logic [1:0]         instr_len;
  logic [PC_BITS-1:0] instr_pc;
  logic               instr_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  tinyqv_instr_aligner #(.PC_BITS(PC_BITS), .BUF_HW(BUF_HW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_len   (instr_len),
    .instr_pc    (instr_pc),
    .instr_ack   (instr_ack)
  );

  always #5 clk = ~clk;

  // Reference model: program-order halfword queue plus PC.
  logic [15:0]        m_q[$];
  logic [PC_BITS-1:0] m_pc = '0;

  function automatic bit m_comp();
    return m_q[0][1:0] != 2'b11;
  endfunction

  function automatic bit m_valid();
    if (m_q.size() == 0) return 1'b0;
    if (m_comp()) return 1'b1;
    return m_q.size() >= 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    bit v;
    v = m_valid();
    chk("model valid", 32'(instr_valid), 32'(v));
    chk("model ready", 32'(fetch_ready), 32'(m_q.size() != BUF_HW));
    chk("model pc", 32'(instr_pc), 32'(m_pc));
    if (v) begin
      if (m_comp()) begin
        chk("model instr16", instr, {16'h0000, m_q[0]});
        chk("model len16", 32'(instr_len), 32'd1);
      end else begin
        chk("model instr32", instr, {m_q[1], m_q[0]});
        chk("model len32", 32'(instr_len), 32'd2);
      end
    end
  endtask

  task automatic model_step(input logic fv, input logic [15:0] d, input logic ack,
                            input logic fl, input logic [PC_BITS-1:0] fpc);
    bit v, rdy;
    int n;
    v   = m_valid();
    rdy = m_q.size() != BUF_HW;
    if (fl) begin
      m_q.delete();
      m_pc = fpc & ~PC_BITS'(1);
    end else begin
      if (ack && v) begin
        n = m_comp() ? 1 : 2;
        repeat (n) void'(m_q.pop_front());
        m_pc = m_pc + PC_BITS'(2 * n);
      end
      if (fv && rdy) m_q.push_back(d);
    end
  endtask

  // Checks current outputs against the model, drives one cycle, advances the model.
  task automatic drive_cycle(input logic fv, input logic [15:0] d, input logic ack,
                             input logic fl, input logic [PC_BITS-1:0] fpc);
    check_model();
    fetch_valid = fv;
    fetch_data  = d;
    instr_ack   = ack;
    flush       = fl;
    flush_pc    = fpc;
    @(posedge clk);
    #1;
    model_step(fv, d, ack, fl, fpc);
    fetch_valid = 1'b0;
    instr_ack   = 1'b0;
    flush       = 1'b0;
  endtask

  typedef struct {
    logic               fv;
    logic [15:0]        data;
    logic               ack;
    logic               fl;
    logic [PC_BITS-1:0] fpc;
    logic               e_valid;
    logic [31:0]        e_instr;
    logic [1:0]         e_len;
    logic [PC_BITS-1:0] e_pc;
    logic               e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic fv, input logic [15:0] d, input logic ack, input logic fl,
                               input logic [PC_BITS-1:0] fpc, input logic ev, input logic [31:0] ei,
                               input logic [1:0] el, input logic [PC_BITS-1:0] ep, input logic er);
    vec_t v;
    v = '{fv, d, ack, fl, fpc, ev, ei, el, ep, er};
    vecs.push_back(v);
  endfunction

  initial begin
    // inputs: fv data ack flush fpc | expected after edge: valid instr len pc ready
    addv(1, 16'h4501, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'h000000, 1); // compressed op
    addv(0, 16'h0000, 1, 0, 0, 0, 32'h0,        2'b01, 24'h000002, 1);
    addv(1, 16'h0513, 0, 0, 0, 0, 32'h0,        2'b01, 24'h000002, 1); // straddle low half
    addv(1, 16'h0010, 0, 0, 0, 1, 32'h00100513, 2'b10, 24'h000002, 1);
    addv(0, 16'h0000, 1, 0, 0, 0, 32'h0,        2'b01, 24'h000006, 1);
    addv(1, 16'h4501, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'h000006, 1); // fill
    addv(1, 16'h4585, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'h000006, 1);
    addv(1, 16'h0513, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'h000006, 1);
    addv(1, 16'h0010, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'h000006, 0);
    addv(1, 16'h1111, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'h000006, 0); // held beat
    addv(1, 16'h1111, 1, 0, 0, 1, 32'h00004585, 2'b01, 24'h000008, 1);
    addv(1, 16'h1111, 0, 0, 0, 1, 32'h00004585, 2'b01, 24'h000008, 0);
    addv(0, 16'h0000, 1, 0, 0, 1, 32'h00100513, 2'b10, 24'h00000A, 1);
    addv(0, 16'h0000, 1, 0, 0, 1, 32'h00001111, 2'b01, 24'h00000E, 1); // order preserved
    addv(0, 16'h0000, 1, 0, 0, 0, 32'h0,        2'b01, 24'h000010, 1);
    addv(1, 16'h4501, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'h000010, 1); // push+pop
    addv(1, 16'h4585, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'h000010, 1);
    addv(1, 16'h0513, 1, 0, 0, 1, 32'h00004585, 2'b01, 24'h000012, 1);
    addv(1, 16'h0010, 1, 0, 0, 1, 32'h00100513, 2'b10, 24'h000014, 1);
    addv(0, 16'h0000, 1, 0, 0, 0, 32'h0,        2'b01, 24'h000018, 1);
    addv(1, 16'h0513, 0, 0, 0, 0, 32'h0,        2'b01, 24'h000018, 1); // flush priority
    addv(1, 16'h0010, 1, 1, 24'h000123, 0, 32'h0, 2'b01, 24'h000122, 1);
    addv(1, 16'h4501, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'h000122, 1);
    addv(0, 16'h0000, 1, 0, 0, 0, 32'h0,        2'b01, 24'h000124, 1);
    addv(0, 16'h0000, 0, 1, 24'hFFFFFF, 0, 32'h0, 2'b01, 24'hFFFFFE, 1); // pc wrap
    addv(1, 16'h4501, 0, 0, 0, 1, 32'h00004501, 2'b01, 24'hFFFFFE, 1);
    addv(0, 16'h0000, 1, 0, 0, 0, 32'h0,        2'b01, 24'h000000, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 32'(instr_valid), 32'd0);
    chk("reset ready", 32'(fetch_ready), 32'd1);
    chk("reset instr", instr, 32'd0);
    chk("reset len", 32'(instr_len), 32'd1);
    chk("reset pc", 32'(instr_pc), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].fv, vecs[i].data, vecs[i].ack, vecs[i].fl, vecs[i].fpc);
      chk($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d pc", i), 32'(instr_pc), 32'(vecs[i].e_pc));
      chk($sformatf("vec%0d ready", i), 32'(fetch_ready), 32'(vecs[i].e_ready));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
        chk($sformatf("vec%0d len", i), 32'(instr_len), 32'(vecs[i].e_len));
      end
    end

    // Async reset mid-stream with three halfwords buffered and a nonzero pc
    drive_cycle(1, 16'h4501, 0, 0, 0);
    drive_cycle(1, 16'h4585, 0, 0, 0);
    drive_cycle(1, 16'h0513, 1, 0, 0);
    drive_cycle(1, 16'h0010, 0, 0, 0);
    check_model();
    #2 rstn = 1'b0;
    #1;
    chk("areset valid", 32'(instr_valid), 32'd0);
    chk("areset ready", 32'(fetch_ready), 32'd1);
    chk("areset pc", 32'(instr_pc), 32'd0);
    chk("areset instr", instr, 32'd0);
    m_q.delete();
    m_pc = '0;
    @(posedge clk);
    #1 rstn = 1'b1;
    drive_cycle(1, 16'h4501, 0, 0, 0);
    chk("post-reset valid", 32'(instr_valid), 32'd1);
    chk("post-reset instr", instr, 32'h00004501);
    chk("post-reset pc", 32'(instr_pc), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) d[1:0] = 2'b11;
      drive_cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 50) == 0, PC_BITS'($urandom));
    end
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
